mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the fetch-stage instruction read port and the memory-stage data read/write port.
- Sits between the pipeline and the RAM.
- Converts contention and memory read latency into fetch-stall and memory-stall requests, which the control unit ORs into its stall/flush logic.
- Data side has priority by default; a starvation guard forces periodic instruction grants.

Parameters:
- MEM_LAT, 1, read latency in cycles from memRd_o high to memRData_i valid (legal range 1..7).
- STARVE_MAX, 4, consecutive denied instruction cycles before the instruction port wins the next conflict. 0 disables the guard (pure data priority).

Ports:
- clk_i  in  1  clock, rising edge
- reset_i  in  1  reset, synchronous, active-low
- iReq_i  in  1  instruction read request; held until iValid_o
- iAddr_i  in  32  instruction byte address; stable while iReq_i
- iRData_o  out  32  instruction read data; valid when iValid_o
- iValid_o  out  1  instruction read complete (one-cycle pulse)
- dReq_i  in  1  data request; held until dValid_o
- dWe_i  in  1  1 = write, 0 = read
- dAddr_i  in  32  data byte address
- dWData_i  in  32  write data
- dWMask_i  in  4  byte write mask
- dRData_o  out  32  data read result
- dValid_o  out  1  data access complete (one-cycle pulse)
- fStall_o  out  1  fetch stall request
- mStall_o  out  1  memory-stage stall request
- memAddr_o  out  32  word address to RAM, equal to the byte address with bits [1:0] dropped
- memRd_o  out  1  RAM read strobe
- memWe_o  out  1  RAM write strobe
- memWData_o  out  32  RAM write data
- memWMask_o  out  4  RAM byte mask
- memRData_i  in  32  RAM read data

Behaviour:
- State machine states:
  - IDLE.
  - I_WAIT: instruction read in flight.
  - D_WAIT: data read in flight.
  - Down-counter latCnt, 3 bits.
- Reset (reset_i low at a clock edge):
  - State goes to IDLE; latCnt = 0; starveCnt = 0.
  - memRd_o = memWe_o = 0; memAddr_o, memWData_o, memWMask_o = 0.
  - iValid_o = dValid_o = 0.
  - Any in-flight read is discarded: no valid pulse occurs after reset.
- IDLE grant rules:
  - Only dReq_i: grant D.
  - Only iReq_i: grant I.
  - Both requesting: grant D unless STARVE_MAX != 0 and starveCnt == STARVE_MAX, in which case grant I.
- Grant I, or grant D read:
  - Issue memRd_o = 1 with the address for one cycle only.
  - latCnt loads MEM_LAT-1; go to I_WAIT or D_WAIT.
- Grant D write:
  - Drive memWe_o, memWData_o and memWMask_o combinationally in the same cycle.
  - dValid_o = 1 in that same cycle; state stays IDLE.
  - Write latency is 0 extra cycles.
- I_WAIT / D_WAIT:
  - latCnt decrements each cycle.
  - When latCnt == 0 and MEM_LAT cycles have elapsed since issue, pulse iValid_o or dValid_o for one cycle; the matching RData_o equals memRData_i in that cycle (combinational pass-through).
  - Next state is IDLE.
- Read latency: the valid pulse comes exactly MEM_LAT cycles after the issue cycle. The next grant is possible the cycle after the valid pulse, so a back-to-back read costs MEM_LAT+1 cycles.
- starveCnt:
  - Increments, saturating at STARVE_MAX, in each IDLE cycle where iReq_i = 1 and D is granted.
  - Clears on every I grant.
  - Holds otherwise.
- Stall outputs (combinational): fStall_o = iReq_i & ~iValid_o; mStall_o = dReq_i & ~dValid_o.
- A request deasserted while its read is in flight is a protocol violation. The read still completes and the valid pulse still fires; the requester ignores it.
- Addresses: bits [1:0] are ignored. No misalignment check; that is done upstream.
- Output idle values: when not issuing, memRd_o = memWe_o = 0 and memWMask_o = 0. memAddr_o holds its last value.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs conflictCnt_o[31:0] and waitCnt_o[31:0].
  - conflictCnt_o counts IDLE cycles with iReq_i & dReq_i.
  - waitCnt_o counts cycles where fStall_o | mStall_o is high.
  - Both wrap at 2^32 and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-read: MEM_LAT=3, iReq at 0x100, reset_i low in cycle 1 after issue -> no iValid_o ever; all mem strobes 0 on the following cycle.
- Single I read: MEM_LAT=2, iReq at 0x40, RAM returns 0xDEADBEEF -> memRd_o high cycle 0 with memAddr_o=0x10; iValid_o high cycle 2 with iRData_o=0xDEADBEEF; fStall_o high in cycles 0-1.
- D write: dReq, dWe=1, addr 0x200, data 0x12345678, mask 0x3 -> same cycle memWe_o=1, memAddr_o=0x80, memWMask_o=0x3, dValid_o=1, mStall_o=0.
- Simultaneous requests: MEM_LAT=1, iReq and dReq (read) both high -> D is served first (valid at cycle 1), I is issued at cycle 2, iValid_o at cycle 3.
- Starvation guard: STARVE_MAX=2; dReq reads held continuously and iReq held -> I granted on the third conflict; starveCnt returns to 0.
- Perf counters (MEM_ARB_PERF_EN): the simultaneous-requests scenario -> conflictCnt_o=1; waitCnt_o equals the count of cycles in which either stall output was high.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between fetch and data ports; `MEM_ARB_PERF_EN adds conflictCnt_o/waitCnt_o
module mem_port_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        iReq_i,
  input  logic [31:0] iAddr_i,
  output logic [31:0] iRData_o,
  output logic        iValid_o,
  input  logic        dReq_i,
  input  logic        dWe_i,
  input  logic [31:0] dAddr_i,
  input  logic [31:0] dWData_i,
  input  logic [3:0]  dWMask_i,
  output logic [31:0] dRData_o,
  output logic        dValid_o,
  output logic        fStall_o,
  output logic        mStall_o,
  output logic [31:0] memAddr_o,
  output logic        memRd_o,
  output logic        memWe_o,
  output logic [31:0] memWData_o,
  output logic [3:0]  memWMask_o,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0] conflictCnt_o,
  output logic [31:0] waitCnt_o,
`endif
  input  logic [31:0] memRData_i
);
  localparam int SW = $clog2(STARVE_MAX + 2);
  typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT} state_t;
  state_t        state;
  logic [2:0]    lat_cnt;
  logic [SW-1:0] starve_cnt;
  logic [31:0]   addr_q;
  logic          idle, starved, grant_i, grant_d, done;
  always_comb begin
    idle       = reset_i && state == IDLE;
    starved    = STARVE_MAX != 0 && starve_cnt == SW'(STARVE_MAX);
    grant_i    = idle && iReq_i && (!dReq_i || starved);
    grant_d    = idle && dReq_i && !grant_i;
    done       = reset_i && state != IDLE && lat_cnt == 3'd0;
    memRd_o    = grant_i || (grant_d && !dWe_i);
    memWe_o    = grant_d && dWe_i;
    memAddr_o  = grant_i ? iAddr_i >> 2 : grant_d ? dAddr_i >> 2 : addr_q;
    memWData_o = memWe_o ? dWData_i : '0;
    memWMask_o = memWe_o ? dWMask_i : '0;
    iValid_o   = done && state == I_WAIT;
    dValid_o   = memWe_o || (done && state == D_WAIT);
    iRData_o   = memRData_i;
    dRData_o   = memRData_i;
    fStall_o   = iReq_i && !iValid_o;
    mStall_o   = dReq_i && !dValid_o;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      addr_q     <= '0;
    end else begin
      addr_q     <= memAddr_o;
      lat_cnt    <= memRd_o ? 3'(MEM_LAT - 1) : (state != IDLE && lat_cnt != 3'd0) ? lat_cnt - 3'd1 : lat_cnt;
      state      <= grant_i ? I_WAIT : (grant_d && !dWe_i) ? D_WAIT : done ? IDLE : state;
      starve_cnt <= grant_i ? '0 : (grant_d && iReq_i && starve_cnt != SW'(STARVE_MAX)) ? starve_cnt + SW'(1) : starve_cnt;
    end
  end
`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      conflictCnt_o <= '0;
      waitCnt_o     <= '0;
    end else begin
      conflictCnt_o <= conflictCnt_o + 32'(state == IDLE && iReq_i && dReq_i);
      waitCnt_o     <= waitCnt_o + 32'(fStall_o || mStall_o);
    end
  end
`endif
endmodule
